brew_sequencer: RTL and testbench
=================================

Name: brew_sequencer

Overview:
Parametrised successor brewery controller for one brew kettle. It runs a cleaning cycle, then fill and a step mash with N_RESTS programmable temperature rests, each with a closed-loop thermostat and a tick-driven hold timer. It finishes with a multi-pass sparge. It sits between the kettle sensor front-end (temp, level) and the actuator drivers (heater, agitator, grain chute, 3-bit pump valve bank), and is started by the plant supervisor.

Parameters:
DW, 8, width of temp, level and per-rest target temperatures
TW, 8, width of per-rest hold times and the rest timer (ticks)
N_RESTS, 3, number of mash rests (1..8)
SPARGE_PASSES, 2, number of sparge refill passes (1..15)
HYST, 2, thermostat hysteresis (temp units)
T_SAFE, 30, cool-down release temperature
T_STERILE, 80, sterilise target temperature
T_MAX, 95, over-temperature fault threshold
L_PREPARE, 125, fill target level
L_SPARGE_START, 70, level that triggers a sparge refill
L_SPARGE_END, 40, level that ends a sparge refill pass
L_LOW, 20, level treated as drained

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
start  in  1  level-sampled start request, honoured only in IDLE
tick  in  1  one-cycle timebase strobe (e.g. 1 s)
temp  in  DW  kettle temperature
level  in  DW  kettle level
rest_temp  in  N_RESTS*DW  rest targets; rest i at bits [i*DW +: DW]
rest_time  in  N_RESTS*TW  rest hold times in ticks, same packing
heat  out  1  heater enable
agitate  out  1  agitator enable
chute  out  1  grain chute open
pump  out  3  valve bank {IN,OUT,TANK}: OFF 000, WASTE 010, TO_TANK 011, WATER 100, SPARGE 111
state  out  4  current state code
rest_idx  out  3  active rest index
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on brew completion
fault  out  1  high in FAULT

Behaviour:
- Reset and clock: reset, synchronous, active-low; clock clk. All outputs are registered. On reset: state IDLE, every output 0, pump OFF, timer 0, pass counter 0.
- States (codes): IDLE 0, DISPOSAL 1, STERILISE 2, COOL 3, FILL 4, MASH_HEAT 5, MASH_REST 6, SPARGE 7, SPARGE_B 8, DONE 9, FAULT 10.
- IDLE, start=1: if level!=0, go to DISPOSAL with pump WASTE. Otherwise go to FILL with pump WATER.
- DISPOSAL: when level==0, go to STERILISE with pump OFF and heat 1.
- STERILISE: when temp>=T_STERILE, go to COOL with heat 0.
- COOL: when temp<=T_SAFE, go to FILL with pump WATER.
- FILL: when level>=L_PREPARE, go to MASH_HEAT with pump OFF, agitate 1, rest_idx 0, and chute high for exactly one cycle.
- Thermostat (MASH_HEAT and MASH_REST), with tgt = rest_temp[rest_idx]: heat is set to 1 when temp < tgt-HYST and cleared to 0 when temp >= tgt; between those it holds. tgt-HYST saturates at 0.
- MASH_HEAT: when temp>=tgt, go to MASH_REST and clear the timer.
- MASH_REST: the timer increments on tick and saturates. When timer==rest_time[rest_idx]:
  - if this is the last rest, go to SPARGE with heat 0, agitate 0, pump TO_TANK;
  - otherwise rest_idx+1, then MASH_HEAT.
  - rest_time 0 leaves the rest in the cycle after entry.
- SPARGE:
  - level<=L_LOW has priority: go to DONE with pump OFF.
  - Else, if level<L_SPARGE_START and passes<SPARGE_PASSES: go to SPARGE_B with pump SPARGE.
  - Once passes==SPARGE_PASSES, SPARGE stays in TO_TANK until drained.
- SPARGE_B: when level<L_SPARGE_END, increment passes, return to SPARGE with pump TO_TANK.
- DONE: done=1 for this one cycle, then IDLE; the pass counter clears.
- FAULT: in any state, temp>=T_MAX forces FAULT. This has priority over all other transitions in the same cycle. In FAULT, heat, agitate and chute are 0 and pump is OFF. FAULT is exited only by reset.
- start outside IDLE is ignored. Reset mid-operation returns to the reset state within one cycle, regardless of state.

Optional Feature:
BREW_WATCHDOG_EN:
- When defined: a parameter WD_TICKS (default 200) is added. A watchdog counter clears on every state change and increments on tick in every state except IDLE and FAULT. Reaching WD_TICKS forces FAULT, with the same priority as over-temperature.
- When undefined: there is no watchdog counter and no WD_TICKS, and only over-temperature causes FAULT.

Test Plan:
1. Reset with level=0, start=1 -> next cycle state FILL, pump 100, busy 1. Level ramped to 125 -> MASH_HEAT, one-cycle chute pulse, agitate 1.
2. Start with level=50 -> DISPOSAL, pump 010. Level 0 -> STERILISE, heat 1. Temp 80 -> COOL, heat 0. Temp 30 -> FILL.
3. Rests {52,64,72} with times {3,0,2}, temp stepped to each target:
   - each rest holds for exactly 3, 0 and 2 ticks;
   - rest_idx steps 0,1,2;
   - heat toggles at 49 and 52 for rest 0.
4. SPARGE_PASSES=2, level driven 65 -> 35 twice, then to 20 -> pump 111, 011, 111, 011, then DONE with one-cycle done, then IDLE.
5. temp=95 during MASH_REST while the rest timer also expires in that cycle -> FAULT (code 10), all actuators 0, start ignored. Reset=0 then recovers to IDLE.
6. Reset asserted in SPARGE_B -> next cycle state 0, pump 000, all outputs 0.

Source files
------------

// File: rtl/brew_sequencer.sv
// brew_sequencer
// Brew kettle controller: cleaning cycle (disposal, sterilise, cool), fill,
// step mash with N_RESTS thermostat-controlled timed rests, then a multi-pass
// sparge. All outputs are registered.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   start      start request, only acted on in IDLE
//   tick       one-cycle timebase strobe for the rest timer
//   temp       kettle temperature
//   level      kettle level
//   rest_temp  packed rest target temperatures, rest i at [i*DW +: DW]
//   rest_time  packed rest hold times (ticks), rest i at [i*TW +: TW]
//   heat       heater enable
//   agitate    agitator enable
//   chute      grain chute open (one-cycle pulse at mash-in)
//   pump       valve bank {IN,OUT,TANK}
//   state      current state code
//   rest_idx   active rest index
//   busy       high whenever not IDLE
//   done       one-cycle pulse on brew completion
//   fault      high in FAULT
//
// Optional build macro: BREW_WATCHDOG_EN adds a per-state watchdog (parameter
// WD_TICKS) that forces FAULT when a state lasts WD_TICKS ticks.

module brew_sequencer #(
   parameter int DW             = 8,
   parameter int TW             = 8,
   parameter int N_RESTS        = 3,
   parameter int SPARGE_PASSES  = 2,
   parameter int HYST           = 2,
   parameter int T_SAFE         = 30,
   parameter int T_STERILE      = 80,
   parameter int T_MAX          = 95,
   parameter int L_PREPARE      = 125,
   parameter int L_SPARGE_START = 70,
   parameter int L_SPARGE_END   = 40,
   parameter int L_LOW          = 20
`ifdef BREW_WATCHDOG_EN
   ,
   parameter int WD_TICKS       = 200
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  tick,
   input  logic [DW-1:0]         temp,
   input  logic [DW-1:0]         level,
   input  logic [N_RESTS*DW-1:0] rest_temp,
   input  logic [N_RESTS*TW-1:0] rest_time,
   output logic                  heat,
   output logic                  agitate,
   output logic                  chute,
   output logic [2:0]            pump,
   output logic [3:0]            state,
   output logic [2:0]            rest_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  fault
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      DISPOSAL  = 4'd1,
      STERILISE = 4'd2,
      COOL      = 4'd3,
      FILL      = 4'd4,
      MASH_HEAT = 4'd5,
      MASH_REST = 4'd6,
      SPARGE    = 4'd7,
      SPARGE_B  = 4'd8,
      DONE      = 4'd9,
      FAULT     = 4'd10
   } state_t;

   localparam logic [2:0] PUMP_OFF     = 3'b000;
   localparam logic [2:0] PUMP_WASTE   = 3'b010;
   localparam logic [2:0] PUMP_TO_TANK = 3'b011;
   localparam logic [2:0] PUMP_WATER   = 3'b100;
   localparam logic [2:0] PUMP_SPARGE  = 3'b111;

   localparam logic [DW-1:0] HYST_W     = DW'(HYST);
   localparam logic [DW-1:0] T_SAFE_W   = DW'(T_SAFE);
   localparam logic [DW-1:0] T_STER_W   = DW'(T_STERILE);
   localparam logic [DW-1:0] T_MAX_W    = DW'(T_MAX);
   localparam logic [DW-1:0] L_PREP_W   = DW'(L_PREPARE);
   localparam logic [DW-1:0] L_SSTART_W = DW'(L_SPARGE_START);
   localparam logic [DW-1:0] L_SEND_W   = DW'(L_SPARGE_END);
   localparam logic [DW-1:0] L_LOW_W    = DW'(L_LOW);
   localparam logic [2:0]    LAST_IDX   = 3'(N_RESTS - 1);
   localparam logic [3:0]    PASSES_W   = 4'(SPARGE_PASSES);

   state_t          state_reg, state_next;
   logic [2:0]      rest_idx_reg, rest_idx_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic [3:0]      pass_reg, pass_next;
   logic            heat_reg, heat_next;
   logic            agitate_reg, agitate_next;
   logic            chute_reg, chute_next;
   logic [2:0]      pump_reg, pump_next;
   logic            done_reg, done_next;
   logic            busy_reg;
   logic            fault_reg;
   logic            wd_expired;

   // Unpack the rest tables into 8-entry arrays so the 3-bit rest index
   // addresses them directly; unused slots read as zero.
   logic [DW-1:0] tgt_arr  [8];
   logic [TW-1:0] hold_arr [8];

   for (genvar gi = 0; gi < 8; gi++) begin : g_rest
      if (gi < N_RESTS) begin : g_used
         assign tgt_arr[gi]  = rest_temp[gi*DW +: DW];
         assign hold_arr[gi] = rest_time[gi*TW +: TW];
      end else begin : g_unused
         assign tgt_arr[gi]  = '0;
         assign hold_arr[gi] = '0;
      end
   end

   logic [DW-1:0] tgt;
   logic [DW-1:0] tgt_lo;
   logic [TW-1:0] hold;

   assign tgt    = tgt_arr[rest_idx_reg];
   assign hold   = hold_arr[rest_idx_reg];
   // Lower thermostat threshold saturates at zero for very low targets.
   assign tgt_lo = (tgt > HYST_W) ? (tgt - HYST_W) : '0;

`ifdef BREW_WATCHDOG_EN
   localparam int WD_W = $clog2(WD_TICKS + 1);
   logic [WD_W-1:0] wd_reg, wd_next;

   assign wd_expired = (wd_reg >= WD_W'(WD_TICKS));

   always_comb begin
      wd_next = wd_reg;
      if (state_next != state_reg)
         wd_next = '0;
      else if (tick && state_reg != IDLE && state_reg != FAULT && !wd_expired)
         wd_next = wd_reg + 1'b1;
   end
`else
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_next    = state_reg;
      rest_idx_next = rest_idx_reg;
      timer_next    = timer_reg;
      pass_next     = pass_reg;
      heat_next     = heat_reg;
      agitate_next  = agitate_reg;
      chute_next    = 1'b0;
      pump_next     = pump_reg;
      done_next     = 1'b0;

      // Hysteresis thermostat during the mash; holds between thresholds.
      if (state_reg == MASH_HEAT || state_reg == MASH_REST) begin
         if (temp >= tgt)
            heat_next = 1'b0;
         else if (temp < tgt_lo)
            heat_next = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            if (start) begin
               if (level != '0) begin
                  state_next = DISPOSAL;
                  pump_next  = PUMP_WASTE;
               end else begin
                  state_next = FILL;
                  pump_next  = PUMP_WATER;
               end
            end
         end
         DISPOSAL: begin
            if (level == '0) begin
               state_next = STERILISE;
               pump_next  = PUMP_OFF;
               heat_next  = 1'b1;
            end
         end
         STERILISE: begin
            if (temp >= T_STER_W) begin
               state_next = COOL;
               heat_next  = 1'b0;
            end
         end
         COOL: begin
            if (temp <= T_SAFE_W) begin
               state_next = FILL;
               pump_next  = PUMP_WATER;
            end
         end
         FILL: begin
            if (level >= L_PREP_W) begin
               state_next    = MASH_HEAT;
               pump_next     = PUMP_OFF;
               agitate_next  = 1'b1;
               rest_idx_next = 3'd0;
               chute_next    = 1'b1;
            end
         end
         MASH_HEAT: begin
            if (temp >= tgt) begin
               state_next = MASH_REST;
               timer_next = '0;
            end
         end
         MASH_REST: begin
            if (timer_reg == hold) begin
               if (rest_idx_reg == LAST_IDX) begin
                  state_next   = SPARGE;
                  heat_next    = 1'b0;
                  agitate_next = 1'b0;
                  pump_next    = PUMP_TO_TANK;
               end else begin
                  state_next    = MASH_HEAT;
                  rest_idx_next = rest_idx_reg + 3'd1;
               end
            end else if (tick && timer_reg != '1) begin
               timer_next = timer_reg + 1'b1;
            end
         end
         SPARGE: begin
            if (level <= L_LOW_W) begin
               state_next = DONE;
               pump_next  = PUMP_OFF;
               done_next  = 1'b1;
            end else if (level < L_SSTART_W && pass_reg < PASSES_W) begin
               state_next = SPARGE_B;
               pump_next  = PUMP_SPARGE;
            end
         end
         SPARGE_B: begin
            if (level < L_SEND_W) begin
               state_next = SPARGE;
               pass_next  = pass_reg + 4'd1;
               pump_next  = PUMP_TO_TANK;
            end
         end
         DONE: begin
            state_next = IDLE;
            pass_next  = 4'd0;
         end
         FAULT: state_next = FAULT;
         default: state_next = FAULT;
      endcase

      // Over-temperature / watchdog pre-empt whatever transition was chosen,
      // so counters and index stay as they were.
      if (temp >= T_MAX_W || wd_expired)
         state_next = FAULT;

      if (state_next == FAULT) begin
         rest_idx_next = rest_idx_reg;
         timer_next    = timer_reg;
         pass_next     = pass_reg;
         heat_next     = 1'b0;
         agitate_next  = 1'b0;
         chute_next    = 1'b0;
         pump_next     = PUMP_OFF;
         done_next     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= IDLE;
         rest_idx_reg <= 3'd0;
         timer_reg    <= '0;
         pass_reg     <= 4'd0;
         heat_reg     <= 1'b0;
         agitate_reg  <= 1'b0;
         chute_reg    <= 1'b0;
         pump_reg     <= PUMP_OFF;
         done_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         fault_reg    <= 1'b0;
`ifdef BREW_WATCHDOG_EN
         wd_reg       <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         rest_idx_reg <= rest_idx_next;
         timer_reg    <= timer_next;
         pass_reg     <= pass_next;
         heat_reg     <= heat_next;
         agitate_reg  <= agitate_next;
         chute_reg    <= chute_next;
         pump_reg     <= pump_next;
         done_reg     <= done_next;
         busy_reg     <= (state_next != IDLE);
         fault_reg    <= (state_next == FAULT);
`ifdef BREW_WATCHDOG_EN
         wd_reg       <= wd_next;
`endif
      end
   end

   assign state    = state_reg;
   assign rest_idx = rest_idx_reg;
   assign heat     = heat_reg;
   assign agitate  = agitate_reg;
   assign chute    = chute_reg;
   assign pump     = pump_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign fault    = fault_reg;

endmodule

// File: tb/tb_brew_sequencer.sv
// Testbench for brew_sequencer: per-scenario tasks build a cycle-by-cycle
// stimulus program; each step's expected output word is pushed to a
// scoreboard when driven and popped/compared one cycle later.
// Output word layout: {state[3:0], rest_idx[2:0], pump[2:0], heat, agitate,
// chute, busy, done, fault}.

module tb_brew_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        tick = 1'b0;
   logic [7:0]  temp = 8'd20;
   logic [7:0]  level = 8'd0;
   logic [23:0] rest_temp = {8'd72, 8'd64, 8'd52};
   logic [23:0] rest_time = {8'd2, 8'd0, 8'd3};
   logic        heat, agitate, chute, busy, done, fault;
   logic [2:0]  pump, rest_idx;
   logic [3:0]  state;

   int checks = 0;
   int errors = 0;

   brew_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .tick      (tick),
      .temp      (temp),
      .level     (level),
      .rest_temp (rest_temp),
      .rest_time (rest_time),
      .heat      (heat),
      .agitate   (agitate),
      .chute     (chute),
      .pump      (pump),
      .state     (state),
      .rest_idx  (rest_idx),
      .busy      (busy),
      .done      (done),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        st;
      logic        tk;
      logic [7:0]  tp;
      logic [7:0]  lv;
      logic [15:0] exp;
      logic [15:0] msk;
      string       nm;
   } step_t;

   step_t prog[$];
   step_t sb[$];

   localparam logic [15:0] FULL  = 16'hFFFF;
   localparam logic [15:0] NO_RI = 16'hF1FF;
   localparam logic [15:0] ZERO  = 16'h0000;

   function automatic logic [15:0] mk(input logic [3:0] st, input logic [2:0] ri,
                                      input logic [2:0] pp, input logic ht,
                                      input logic ag, input logic ch, input logic bz,
                                      input logic dn, input logic ft);
      return {st, ri, pp, ht, ag, ch, bz, dn, ft};
   endfunction

   function automatic logic [15:0] obs();
      return {state, rest_idx, pump, heat, agitate, chute, busy, done, fault};
   endfunction

   function automatic void add(input logic r, input logic s, input logic k,
                               input logic [7:0] tp, input logic [7:0] lv,
                               input logic [15:0] ex, input logic [15:0] m,
                               input string nm);
      step_t x;
      x.rst_n = r; x.st = s; x.tk = k; x.tp = tp; x.lv = lv;
      x.exp = ex; x.msk = m; x.nm = nm;
      prog.push_back(x);
   endfunction

   // Plan 1: reset state, fill from empty, chute pulse
   task automatic test_reset();
      step_t s, e;
      add(0, 1, 0, 20, 0,   ZERO, FULL, "reset_hold");
      add(0, 1, 0, 20, 0,   ZERO, FULL, "reset_hold_start_ignored");
      add(1, 1, 0, 20, 0,   mk(4, 0, 3'b100, 0, 0, 0, 1, 0, 0), FULL, "start_to_fill");
      add(1, 0, 0, 20, 100, mk(4, 0, 3'b100, 0, 0, 0, 1, 0, 0), FULL, "fill_wait_100");
      add(1, 0, 0, 20, 124, mk(4, 0, 3'b100, 0, 0, 0, 1, 0, 0), FULL, "fill_wait_124");
      add(1, 0, 0, 20, 125, mk(5, 0, 3'b000, 0, 1, 1, 1, 0, 0), FULL, "fill_done_chute");
      add(1, 0, 0, 20, 125, mk(5, 0, 3'b000, 1, 1, 0, 1, 0, 0), FULL, "chute_one_cycle");
      while (prog.size() > 0) begin
         s = prog.pop_front();
         reset = s.rst_n; start = s.st; tick = s.tk; temp = s.tp; level = s.lv;
         sb.push_back(s);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ((obs() & e.msk) !== (e.exp & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.nm, obs() & e.msk, e.exp & e.msk);
         end else $display("ok   %s: %h", e.nm, obs());
      end
   endtask

   // Plan 2: cleaning cycle
   task automatic test_clean();
      step_t s, e;
      add(0, 0, 0, 20, 50, ZERO, FULL, "clean_reset");
      add(1, 1, 0, 20, 50, mk(1, 0, 3'b010, 0, 0, 0, 1, 0, 0), FULL, "start_disposal");
      add(1, 1, 0, 20, 10, mk(1, 0, 3'b010, 0, 0, 0, 1, 0, 0), FULL, "disposal_wait");
      add(1, 0, 0, 20, 0,  mk(2, 0, 3'b000, 1, 0, 0, 1, 0, 0), FULL, "sterilise");
      add(1, 0, 0, 79, 0,  mk(2, 0, 3'b000, 1, 0, 0, 1, 0, 0), FULL, "sterilise_79");
      add(1, 0, 0, 80, 0,  mk(3, 0, 3'b000, 0, 0, 0, 1, 0, 0), FULL, "cool");
      add(1, 0, 0, 31, 0,  mk(3, 0, 3'b000, 0, 0, 0, 1, 0, 0), FULL, "cool_31");
      add(1, 0, 0, 30, 0,  mk(4, 0, 3'b100, 0, 0, 0, 1, 0, 0), FULL, "cool_to_fill");
      while (prog.size() > 0) begin
         s = prog.pop_front();
         reset = s.rst_n; start = s.st; tick = s.tk; temp = s.tp; level = s.lv;
         sb.push_back(s);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ((obs() & e.msk) !== (e.exp & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.nm, obs() & e.msk, e.exp & e.msk);
         end else $display("ok   %s: %h", e.nm, obs());
      end
   endtask

   // Plan 3: three rests {52,64,72} held {3,0,2} ticks; ends in SPARGE
   task automatic test_mash();
      step_t s, e;
      rest_temp = {8'd72, 8'd64, 8'd52};
      rest_time = {8'd2, 8'd0, 8'd3};
      add(0, 0, 0, 20, 0,   ZERO, FULL, "mash_reset");
      add(1, 1, 0, 20, 0,   mk(4, 0, 3'b100, 0, 0, 0, 1, 0, 0), FULL, "mash_fill");
      add(1, 0, 0, 20, 125, mk(5, 0, 3'b000, 0, 1, 1, 1, 0, 0), FULL, "mash_in");
      add(1, 0, 0, 49, 125, mk(5, 0, 3'b000, 1, 1, 0, 1, 0, 0), FULL, "heat_on_49");
      add(1, 0, 0, 51, 125, mk(5, 0, 3'b000, 1, 1, 0, 1, 0, 0), FULL, "heat_hold_51");
      add(1, 0, 0, 52, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest0_enter");
      add(1, 0, 0, 49, 125, mk(6, 0, 3'b000, 1, 1, 0, 1, 0, 0), FULL, "rest0_heat_49");
      add(1, 0, 1, 52, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest0_tick1");
      add(1, 0, 1, 52, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest0_tick2");
      add(1, 0, 1, 52, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest0_tick3");
      add(1, 0, 0, 52, 125, mk(5, 1, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest0_exit");
      add(1, 0, 0, 64, 125, mk(6, 1, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest1_enter");
      add(1, 0, 0, 64, 125, mk(5, 2, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest1_zero_time");
      add(1, 0, 0, 72, 125, mk(6, 2, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest2_enter");
      add(1, 0, 1, 72, 125, mk(6, 2, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest2_tick1");
      add(1, 0, 1, 72, 125, mk(6, 2, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "rest2_tick2");
      add(1, 0, 0, 72, 125, mk(7, 2, 3'b011, 0, 0, 0, 1, 0, 0), FULL, "to_sparge");
      while (prog.size() > 0) begin
         s = prog.pop_front();
         reset = s.rst_n; start = s.st; tick = s.tk; temp = s.tp; level = s.lv;
         sb.push_back(s);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ((obs() & e.msk) !== (e.exp & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.nm, obs() & e.msk, e.exp & e.msk);
         end else $display("ok   %s: %h", e.nm, obs());
      end
   endtask

   // Plan 4: two sparge passes, drain, done pulse (continues from test_mash)
   task automatic test_sparge();
      step_t s, e;
      add(1, 0, 0, 60, 65, mk(8, 2, 3'b111, 0, 0, 0, 1, 0, 0), FULL, "sparge_b1");
      add(1, 0, 0, 60, 50, mk(8, 2, 3'b111, 0, 0, 0, 1, 0, 0), FULL, "sparge_b1_hold");
      add(1, 0, 0, 60, 35, mk(7, 2, 3'b011, 0, 0, 0, 1, 0, 0), FULL, "sparge_pass1");
      add(1, 0, 0, 60, 65, mk(8, 2, 3'b111, 0, 0, 0, 1, 0, 0), FULL, "sparge_b2");
      add(1, 0, 0, 60, 35, mk(7, 2, 3'b011, 0, 0, 0, 1, 0, 0), FULL, "sparge_pass2");
      add(1, 0, 0, 60, 35, mk(7, 2, 3'b011, 0, 0, 0, 1, 0, 0), FULL, "passes_exhausted");
      add(1, 0, 0, 60, 21, mk(7, 2, 3'b011, 0, 0, 0, 1, 0, 0), FULL, "drain_21");
      add(1, 0, 0, 60, 20, mk(9, 2, 3'b000, 0, 0, 0, 1, 1, 0), FULL, "done_pulse");
      add(1, 0, 0, 60, 20, ZERO, NO_RI, "idle_after_done");
      add(1, 0, 0, 60, 20, ZERO, NO_RI, "idle_stays");
      while (prog.size() > 0) begin
         s = prog.pop_front();
         reset = s.rst_n; start = s.st; tick = s.tk; temp = s.tp; level = s.lv;
         sb.push_back(s);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ((obs() & e.msk) !== (e.exp & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.nm, obs() & e.msk, e.exp & e.msk);
         end else $display("ok   %s: %h", e.nm, obs());
      end
   endtask

   // Plan 5: over-temperature in the same cycle the rest timer expires
   task automatic test_fault();
      step_t s, e;
      rest_time = {8'd2, 8'd0, 8'd3};
      add(0, 0, 0, 20, 0,   ZERO, FULL, "fault_pre_reset");
      add(1, 1, 0, 20, 0,   mk(4, 0, 3'b100, 0, 0, 0, 1, 0, 0), FULL, "fault_fill");
      add(1, 0, 0, 20, 125, mk(5, 0, 3'b000, 0, 1, 1, 1, 0, 0), FULL, "fault_mash_in");
      add(1, 0, 0, 52, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "fault_rest");
      add(1, 0, 1, 52, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "fault_tick1");
      add(1, 0, 1, 52, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "fault_tick2");
      add(1, 0, 1, 52, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "fault_tick3");
      add(1, 0, 0, 95, 125, mk(10, 0, 3'b000, 0, 0, 0, 1, 0, 1), FULL, "overtemp_priority");
      add(1, 1, 0, 20, 0,   mk(10, 0, 3'b000, 0, 0, 0, 1, 0, 1), FULL, "fault_start_ignored");
      add(1, 1, 0, 20, 0,   mk(10, 0, 3'b000, 0, 0, 0, 1, 0, 1), FULL, "fault_sticky");
      add(0, 1, 0, 20, 0,   ZERO, FULL, "fault_reset");
      add(1, 0, 0, 20, 0,   ZERO, FULL, "fault_recovered");
      while (prog.size() > 0) begin
         s = prog.pop_front();
         reset = s.rst_n; start = s.st; tick = s.tk; temp = s.tp; level = s.lv;
         sb.push_back(s);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ((obs() & e.msk) !== (e.exp & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.nm, obs() & e.msk, e.exp & e.msk);
         end else $display("ok   %s: %h", e.nm, obs());
      end
   endtask

   // Plan 6: zero-length rests straight through to SPARGE_B, then reset
   task automatic test_reset_midrun();
      step_t s, e;
      rest_time = {8'd0, 8'd0, 8'd0};
      add(0, 0, 0, 80, 0,   ZERO, FULL, "mid_pre_reset");
      add(1, 1, 0, 80, 0,   mk(4, 0, 3'b100, 0, 0, 0, 1, 0, 0), FULL, "mid_fill");
      add(1, 0, 0, 80, 125, mk(5, 0, 3'b000, 0, 1, 1, 1, 0, 0), FULL, "mid_mash_in");
      add(1, 0, 0, 80, 125, mk(6, 0, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "mid_rest0");
      add(1, 0, 0, 80, 125, mk(5, 1, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "mid_heat1");
      add(1, 0, 0, 80, 125, mk(6, 1, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "mid_rest1");
      add(1, 0, 0, 80, 125, mk(5, 2, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "mid_heat2");
      add(1, 0, 0, 80, 125, mk(6, 2, 3'b000, 0, 1, 0, 1, 0, 0), FULL, "mid_rest2");
      add(1, 0, 0, 80, 125, mk(7, 2, 3'b011, 0, 0, 0, 1, 0, 0), FULL, "mid_sparge");
      add(1, 0, 0, 80, 65,  mk(8, 2, 3'b111, 0, 0, 0, 1, 0, 0), FULL, "mid_sparge_b");
      add(0, 0, 0, 80, 65,  ZERO, FULL, "reset_in_sparge_b");
      add(1, 0, 0, 80, 65,  ZERO, FULL, "idle_after_reset");
      while (prog.size() > 0) begin
         s = prog.pop_front();
         reset = s.rst_n; start = s.st; tick = s.tk; temp = s.tp; level = s.lv;
         sb.push_back(s);
         @(posedge clk); #1;
         e = sb.pop_front();
         checks++;
         if ((obs() & e.msk) !== (e.exp & e.msk)) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.nm, obs() & e.msk, e.exp & e.msk);
         end else $display("ok   %s: %h", e.nm, obs());
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_mash();
      test_sparge();
      test_fault();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
